// File: rtl/bht_resolve_queue_pkg.sv
// Shared constants for the BHT resolve queue: address width, packed entry width
// and the 2-bit BHT counter encoding (1x predicts taken, 0x predicts not-taken).
package bht_resolve_queue_pkg;

    localparam int IM_ADDR_BIT   = 12;
    localparam int BHT_ENTRY_BIT = 2 * IM_ADDR_BIT + 2;

    typedef enum logic [1:0] {
        BHT_STRONG_NT = 2'b00,
        BHT_WEAK_NT   = 2'b01,
        BHT_WEAK_T    = 2'b10,
        BHT_STRONG_T  = 2'b11
    } bht_state_e;

    function automatic logic bht_predicts_taken(input logic [1:0] state);
        return state[1];
    endfunction

endpackage

// File: rtl/bht_resolve_queue_pred_fifo.sv
// Generic DEPTH x WIDTH in-order FIFO with a synchronous flush that empties the
// queue on the same edge and discards any push presented alongside it.
module bht_resolve_queue_pred_fifo #(
    parameter int WIDTH   = 26,
    parameter int DEPTH   = 4,
    parameter int PTR_BIT = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push_en,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop_en,
    output logic [WIDTH-1:0] head_data,
    output logic             pop_ok,
    output logic             full,
    output logic             empty
);
    import bht_resolve_queue_pkg::*;

    localparam logic [PTR_BIT:0] FULL_CNT = (PTR_BIT + 1)'(DEPTH);

    logic [WIDTH-1:0]   mem_q [DEPTH];
    logic [WIDTH-1:0]   mem_d [DEPTH];
    logic [PTR_BIT-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_BIT-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_BIT:0]   count_q, count_d;
    logic               push_ok;

    assign full      = (count_q == FULL_CNT);
    assign empty     = (count_q == '0);
    assign pop_ok    = pop_en && !empty;
    // A pop in the same cycle frees the slot, so a full queue still accepts.
    assign push_ok   = push_en && (!full || pop_ok);
    assign head_data = mem_q[rd_ptr_q];

    always_comb begin
        mem_d = mem_q;
        if (push_ok && !flush) begin
            mem_d[wr_ptr_q] = push_data;
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) begin
                wr_ptr_d = wr_ptr_q + PTR_BIT'(1);
            end
            if (pop_ok) begin
                rd_ptr_d = rd_ptr_q + PTR_BIT'(1);
            end
            if (push_ok && !pop_ok) begin
                count_d = count_q + (PTR_BIT + 1)'(1);
            end else if (pop_ok && !push_ok) begin
                count_d = count_q - (PTR_BIT + 1)'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/bht_resolve_queue.sv
// Holds fetch-time BHT predictions until execute resolves them, then drives the
// registered BHT update port and a one-cycle fetch redirect/flush on mispredict.
module bht_resolve_queue #(
    parameter int ADDR_BIT = bht_resolve_queue_pkg::IM_ADDR_BIT,
    parameter int DEPTH    = 4,
    parameter int PTR_BIT  = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                push_en,
    input  logic [ADDR_BIT-1:0] push_pc_4,
    input  logic [ADDR_BIT-1:0] push_guess_pc,
    input  logic [1:0]          push_guess_state,
    output logic                full,
    output logic                empty,
    input  logic                pop_en,
    input  logic                pop_is_branch,
    input  logic                pop_taken,
    input  logic [ADDR_BIT-1:0] pop_target,
    output logic                update_en,
    output logic [ADDR_BIT-1:0] update_pc_4,
    output logic [ADDR_BIT-1:0] update_pc_remote,
    output logic [1:0]          update_state_old,
    output logic                branch_succ,
    output logic                redirect_en,
    output logic [ADDR_BIT-1:0] redirect_pc
);
    import bht_resolve_queue_pkg::*;

    localparam int ENTRY_W = 2 * ADDR_BIT + 2;

    // Handshake: push_en is a valid with !full (or a same-cycle pop) as ready;
    // pop_en is a valid whose ready is !empty. Nothing is held across cycles.
    logic [ENTRY_W-1:0]  head_data;
    logic                pop_ok;
    logic                flush;
    logic [ADDR_BIT-1:0] head_pc_4;
    logic [ADDR_BIT-1:0] head_guess_pc;
    logic [1:0]          head_guess_state;
    logic [ADDR_BIT-1:0] actual_pc;
    logic                mispredict;

    logic                update_en_q, update_en_d;
    logic [ADDR_BIT-1:0] update_pc_4_q, update_pc_4_d;
    logic [ADDR_BIT-1:0] update_pc_remote_q, update_pc_remote_d;
    logic [1:0]          update_state_old_q, update_state_old_d;
    logic                branch_succ_q, branch_succ_d;
    logic                redirect_en_q, redirect_en_d;
    logic [ADDR_BIT-1:0] redirect_pc_q, redirect_pc_d;

    bht_resolve_queue_pred_fifo #(
        .WIDTH   (ENTRY_W),
        .DEPTH   (DEPTH),
        .PTR_BIT (PTR_BIT)
    ) u_pred_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .push_en   (push_en),
        .push_data ({push_pc_4, push_guess_pc, push_guess_state}),
        .pop_en    (pop_en),
        .head_data (head_data),
        .pop_ok    (pop_ok),
        .full      (full),
        .empty     (empty)
    );

    assign head_pc_4        = head_data[ENTRY_W-1 -: ADDR_BIT];
    assign head_guess_pc    = head_data[ADDR_BIT+1 -: ADDR_BIT];
    assign head_guess_state = head_data[1:0];

    assign actual_pc  = (pop_is_branch && pop_taken) ? pop_target : head_pc_4;
    assign mispredict = (head_guess_pc != actual_pc);
    // Everything younger than a mispredicted entry is wrong-path.
    assign flush      = pop_ok && mispredict;

    always_comb begin
        update_en_d        = 1'b0;
        update_pc_4_d      = update_pc_4_q;
        update_pc_remote_d = update_pc_remote_q;
        update_state_old_d = update_state_old_q;
        branch_succ_d      = branch_succ_q;
        if (pop_ok && pop_is_branch) begin
            update_en_d        = 1'b1;
            update_pc_4_d      = head_pc_4;
            update_pc_remote_d = pop_target;
            update_state_old_d = head_guess_state;
            branch_succ_d      = pop_taken;
        end
    end

    always_comb begin
        redirect_en_d = flush;
        redirect_pc_d = flush ? actual_pc : redirect_pc_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            update_en_q        <= 1'b0;
            update_pc_4_q      <= '0;
            update_pc_remote_q <= '0;
            update_state_old_q <= '0;
            branch_succ_q      <= 1'b0;
            redirect_en_q      <= 1'b0;
            redirect_pc_q      <= '0;
        end else begin
            update_en_q        <= update_en_d;
            update_pc_4_q      <= update_pc_4_d;
            update_pc_remote_q <= update_pc_remote_d;
            update_state_old_q <= update_state_old_d;
            branch_succ_q      <= branch_succ_d;
            redirect_en_q      <= redirect_en_d;
            redirect_pc_q      <= redirect_pc_d;
        end
    end

    assign update_en        = update_en_q;
    assign update_pc_4      = update_pc_4_q;
    assign update_pc_remote = update_pc_remote_q;
    assign update_state_old = update_state_old_q;
    assign branch_succ      = branch_succ_q;
    assign redirect_en      = redirect_en_q;
    assign redirect_pc      = redirect_pc_q;

endmodule
